// File: rtl/instr_frame_deserializer.sv
// Rebuilds {opcode, address} words from an MSB-first byte stream and flags short/long frames.
// Word valid one cycle after the last byte; byte input stalls while a word waits for m_ready.
module instr_frame_deserializer #(
  parameter int OPCODE_W  = 16,
  parameter int ADDR_W    = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [OPCODE_W-1:0]  m_opcode,
  output logic [ADDR_W-1:0]    m_address,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int W      = OPCODE_W + ADDR_W;
  localparam int NBYTES = W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {COLLECT, FULL, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Only the first NBYTES-1 bytes need storing; the final byte is taken straight from s_data.
  logic [W-9:0]          shift_q, shift_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  vld_q, vld_d;
  logic                  ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0]  ecnt_q, ecnt_d;
  logic                  accept;
  logic                  err_hit;
  logic [W-1:0]          shifted;

  assign s_ready = (state_q != FULL);
  assign accept  = s_valid && s_ready;
  assign shifted = {shift_q, s_data};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    vld_d    = vld_q;
    ferr_d   = 1'b0;
    ecnt_d   = ecnt_q;
    err_hit  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            shift_d = '0;
            if (s_last) begin
              opcode_d = shifted[W-1 -: OPCODE_W];
              addr_d   = shifted[ADDR_W-1:0];
              vld_d    = 1'b1;
              state_d  = FULL;
            end else begin
              err_hit = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_last) begin
            err_hit = 1'b1;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shifted[W-9:0];
          end
        end
      end
      FULL: begin
        if (m_ready) begin
          vld_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (accept && s_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (err_hit) begin
      ferr_d = 1'b1;
      if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      shift_q  <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign m_opcode  = opcode_q;
  assign m_address = addr_q;
  assign m_valid   = vld_q;
  assign frame_err = ferr_q;
  assign err_count = ecnt_q;

endmodule
